md_unit_ctrl: RTL and testbench

// Multi-cycle multiply/divide sequencer with HI/LO registers for the 5-stage MIPS pipeline.
// E stage issues mult/multu/div/divu, or writes HI/LO directly (mthi/mtlo).
// The block counts out the operation latency and commits the result to HI/LO.
// It drives a stall to the hazard logic while an md-class instruction in D must wait.

---
 rtl/md_unit_ctrl.sv | 145 ++++++++++++++
 tb/tb_md_unit_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer with HI/LO registers for the 5-stage MIPS pipeline.
// Counts out the operation latency, then commits the result to HI/LO.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                        MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Datapath works only on latched operands.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
  end

  // Signed divide via magnitudes; 0x80000000 / -1 wraps to itself.
  always_comb begin
    neg_a = ~op_q[0] & a_q[31];
    neg_b = ~op_q[0] & b_q[31];
    mag_a = neg_a ? (~a_q + 32'd1) : a_q;
    mag_b = neg_b ? (~b_q + 32'd1) : b_q;
    q_mag = '0;
    r_mag = '0;
    if (mag_b != 32'd0) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    quo = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    rem = neg_a ? (~r_mag + 32'd1) : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = RUN;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      unique case (op_q)
        2'b00: {hi_d, lo_d} = prod_s;
        2'b01: {hi_d, lo_d} = prod_u;
        default: begin
          // Divide by zero leaves HI/LO untouched.
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      endcase
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = d_md_use & (start | busy);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: latency, arithmetic,
// stall, mthi/mtlo and reset behaviour.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .d_md_use(d_md_use), .busy(busy),
    .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive start in current cycle T; returns in cycle T+1.
  task automatic issue(input logic [1:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    step();
    start = 1'b0;
  endtask

  // From cycle T+1: busy for n cycles, then result at T+n+1.
  task automatic expect_run(input string tag, input int n,
                            input logic [31:0] eh,
                            input logic [31:0] el);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      step();
    end
    check({tag, "_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00;
    a = '0; b = '0; hi_we = 1'b0; lo_we = 1'b0;
    wdata = '0; d_md_use = 1'b0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    step();

    // 3 * -2 = -6
    issue(2'b00, 32'd3, 32'hFFFF_FFFE);
    expect_run("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    expect_run("multu", 5, 32'h0000_0001, 32'hFFFF_FFFE);

    // 7 / -2 = -3 rem 1
    issue(2'b10, 32'd7, 32'hFFFF_FFFE);
    expect_run("div", 10, 32'h0000_0001, 32'hFFFF_FFFD);

    issue(2'b10, 32'd9, 32'd0);
    expect_run("div0", 10, 32'h0000_0001, 32'hFFFF_FFFD);

    // -7 / 2 = -3 rem -1
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    expect_run("divneg", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_run("divovf", 10, 32'h0000_0000, 32'h8000_0000);

    issue(2'b11, 32'd100, 32'd7);
    expect_run("divu", 10, 32'h0000_0002, 32'h0000_000E);

    issue(2'b11, 32'hFFFF_FFFF, 32'd16);
    expect_run("divu_big", 10, 32'h0000_000F, 32'h0FFF_FFFF);

    // Stall with d_md_use held
    d_md_use = 1'b1;
    start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd5;
    #1;
    check("stall_T", {31'd0, stall}, 32'd1);
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_run", {31'd0, stall}, 32'd1);
      step();
    end
    check("stall_end", {31'd0, stall}, 32'd0);
    check("stall_lo", lo, 32'd10);

    d_md_use = 1'b0;
    start = 1'b1; op = 2'b00; a = 32'd4; b = 32'd4;
    #1;
    check("nostall_T", {31'd0, stall}, 32'd0);
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("nostall_run", {31'd0, stall}, 32'd0);
      step();
    end
    check("nostall_lo", lo, 32'd16);

    // mthi then mtlo
    hi_we = 1'b1; wdata = 32'h1234_5678;
    step();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h9ABC_DEF0;
    check("mthi", hi, 32'h1234_5678);
    step();
    lo_we = 1'b0;
    check("mtlo_hi", hi, 32'h1234_5678);
    check("mtlo", lo, 32'h9ABC_DEF0);

    // hi_we during busy, start while busy, operand change
    issue(2'b00, 32'd5, 32'd6);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    start = 1'b1; op = 2'b11; a = 32'd99; b = 32'd3;
    step();
    hi_we = 1'b0; start = 1'b0;
    check("busy_we_hi", hi, 32'h1234_5678);
    check("busy_start", {31'd0, busy}, 32'd1);
    expect_run("latched", 4, 32'd0, 32'd30);

    // start and mthi in the same cycle: write dropped
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA_AAAA;
    issue(2'b00, 32'd2, 32'd3);
    hi_we = 1'b0; lo_we = 1'b0;
    check("startwin_hi", hi, 32'd0);
    check("startwin_lo", lo, 32'd30);
    expect_run("startwin", 5, 32'd0, 32'd6);

    // Reset mid-divide
    issue(2'b10, 32'd50, 32'd7);
    step(); step(); step();
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_hi", hi, 32'd0);
    check("rstmid_lo", lo, 32'd0);
    #2;
    reset = 1'b0;
    step();
    check("rstmid_idle", {31'd0, busy}, 32'd0);
    issue(2'b00, 32'd3, 32'hFFFF_FFFE);
    expect_run("postrst", 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
